// File: rtl/data_mem_pkg.sv
// Shared types for the data memory load/store unit: access sizes, FSM states
// and the alignment-error predicate.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // lane is the byte offset within the word; words are an even number of bytes,
    // so lane[0] equals the byte-address LSB.
    function automatic logic misaligned(input logic [1:0] size, input logic [7:0] lane);
        return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 8'd0));
    endfunction

endpackage

// File: rtl/data_mem_lane_fmt.sv
// Lane steering for the data memory: byte enables and shifted data for stores,
// field extraction with sign/zero extension for loads.
module data_mem_lane_fmt
    import data_mem_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int BPW    = DATA_W / 8,
    localparam int LANE_W = $clog2(BPW)
) (
    input  logic [1:0]        st_size,
    input  logic [LANE_W-1:0] st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [BPW-1:0]    st_be,
    output logic [DATA_W-1:0] st_data,
    input  logic [1:0]        ld_size,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data
);
    logic [BPW-1:0] st_mask;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;

    always_comb begin
        st_mask = '1;
        case (st_size)
            SZ_BYTE: st_mask = BPW'(1);
            SZ_HALF: st_mask = BPW'(3);
            default: ;
        endcase
        st_be   = st_mask << st_lane;
        st_data = st_wdata << {st_lane, 3'b000};

        ld_byte = 8'(ld_word >> {ld_lane, 3'b000});
        ld_half = 16'(ld_word >> {ld_lane, 3'b000});
        case (ld_size)
            SZ_BYTE: ld_data = {{(DATA_W-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{(DATA_W-16){~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-port data memory with sized load/store, alignment/range checks and
// one-cycle responses. DATA_MEM_LSU_CLEAR_EN adds a post-reset zero-fill sequencer.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH * DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int BPW    = DATA_W / 8;
    localparam int LANE_W = $clog2(BPW);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] BPW_A   = ADDR_W'(BPW);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic              ready;
    logic              accept, err, wr_en, rd_en;
    logic [ADDR_W-1:0] word_idx;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  mem_idx;
    logic [BPW-1:0]    st_be;
    logic [DATA_W-1:0] st_data, rd_word, ld_data;

    logic              rsp_valid_q, rsp_err_q, ld_q, ld_uns_q;
    logic [1:0]        ld_size_q;
    logic [LANE_W-1:0] ld_lane_q;

`ifdef DATA_MEM_LSU_CLEAR_EN
    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clearing;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            else                                clr_idx_d = clr_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign ready    = (state_q == ST_RUN);
`else
    logic run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    assign ready = run_q;
`endif

    assign accept   = req_valid && ready;
    assign word_idx = req_addr / BPW_A;
    assign lane     = LANE_W'(req_addr % BPW_A);
    assign mem_idx  = IDX_W'(word_idx);
    assign err      = misaligned(req_size, 8'(lane)) || (word_idx >= DEPTH_A) || (req_size == 2'b11);
    assign wr_en    = accept && !err && req_we;
    assign rd_en    = accept && !err && !req_we;

    data_mem_lane_fmt #(.DATA_W(DATA_W)) u_lane_fmt (
        .st_size     (req_size),
        .st_lane     (lane),
        .st_wdata    (req_wdata),
        .st_be       (st_be),
        .st_data     (st_data),
        .ld_size     (ld_size_q),
        .ld_lane     (ld_lane_q),
        .ld_unsigned (ld_uns_q),
        .ld_word     (rd_word),
        .ld_data     (ld_data)
    );

    // One byte-wide array per lane so each maps onto a plain RAM with its own write enable.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
`ifdef DATA_MEM_LSU_CLEAR_EN
            if (clearing) mem_q[clr_idx_q] <= 8'h00;
            else
`endif
            if (wr_en && st_be[gi]) mem_q[mem_idx] <= st_data[8*gi +: 8];
            if (rd_en) rd_q <= mem_q[mem_idx];
        end

        assign rd_word[8*gi +: 8] = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_q        <= 1'b0;
            ld_uns_q    <= 1'b0;
            ld_size_q   <= '0;
            ld_lane_q   <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            ld_q        <= rd_en;
            if (rd_en) begin
                ld_uns_q  <= req_unsigned;
                ld_size_q <= req_size;
                ld_lane_q <= lane;
            end
        end
    end

    assign req_ready = ready;
    assign init_done = ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = ld_q ? ld_data : '0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu (DATA_W=32); a DEPTH=63 copy shares the
// request bus to exercise the out-of-range word index.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;

    logic        req_ready, rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_rdata;
    logic        req_ready_63, rsp_valid_63, rsp_err_63, init_done_63;
    logic [31:0] rsp_rdata_63;

`ifdef DATA_MEM_LSU_CLEAR_EN
    localparam int EXP_READY = 64;
`else
    localparam int EXP_READY = 1;
`endif

    data_mem_lsu #(.DATA_W(32), .DEPTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_done(init_done)
    );

    data_mem_lsu #(.DATA_W(32), .DEPTH(63)) u_dut63 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_63), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_63), .rsp_rdata(rsp_rdata_63),
        .rsp_err(rsp_err_63), .init_done(init_done_63)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          due;
        logic        chk63;
        logic [31:0] rdata63;
        logic        err63;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Response monitor: every response must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp %-14s rdata=%08h err=%0b cyc=%0d", mon_e.tag, rsp_rdata, rsp_err, cyc);
                check({mon_e.tag, "_lat"}, 32'(cyc), 32'(mon_e.due));
                check({mon_e.tag, "_data"}, rsp_rdata, mon_e.rdata);
                check({mon_e.tag, "_err"}, 32'(rsp_err), 32'(mon_e.err));
                if (mon_e.chk63) begin
                    check({mon_e.tag, "_d63_valid"}, 32'(rsp_valid_63), 32'd1);
                    check({mon_e.tag, "_d63_data"}, rsp_rdata_63, mon_e.rdata63);
                    check({mon_e.tag, "_d63_err"}, 32'(rsp_err_63), 32'(mon_e.err63));
                end
            end
        end
    end

    task automatic send(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic exp_e,
                        input logic chk63, input logic [31:0] d63, input logic e63);
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        e.tag = tag; e.rdata = exp_d; e.err = exp_e; e.due = cyc + 1;
        e.chk63 = chk63; e.rdata63 = d63; e.err63 = e63;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input int exp_n);
        int n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_latency", 32'(n), 32'(exp_n));
        check("init_done", 32'(init_done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_init"}, 32'(init_done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_ready(EXP_READY);

`ifdef DATA_MEM_LSU_CLEAR_EN
        send("ld_cleared", 1'b0, 2'b10, 1'b0, 8'd24, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
`endif
        // word store then immediate load of the same word
        send("st_w24", 1'b1, 2'b10, 1'b0, 8'd24, 32'd78, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_w24", 1'b0, 2'b10, 1'b0, 8'd24, 32'h0, 32'd78, 1'b0, 1'b0, 32'h0, 1'b0);

        // byte lanes
        send("st_w8", 1'b1, 2'b10, 1'b0, 8'd8, 32'h11223344, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("st_b10", 1'b1, 2'b00, 1'b0, 8'd10, 32'hABCDEFF0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_b10_s", 1'b0, 2'b00, 1'b0, 8'd10, 32'h0, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_b10_u", 1'b0, 2'b00, 1'b1, 8'd10, 32'h0, 32'h000000F0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_w8", 1'b0, 2'b10, 1'b0, 8'd8, 32'h0, 32'h11F03344, 1'b0, 1'b1, 32'h11F03344, 1'b0);
        send("ld_h8_s", 1'b0, 2'b01, 1'b0, 8'd8, 32'h0, 32'h00003344, 1'b0, 1'b0, 32'h0, 1'b0);

        // halfword lanes and extension
        send("st_w12", 1'b1, 2'b10, 1'b0, 8'd12, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("st_h14", 1'b1, 2'b01, 1'b0, 8'd14, 32'hFFFF8001, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_h14_s", 1'b0, 2'b01, 1'b0, 8'd14, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_h14_u", 1'b0, 2'b01, 1'b1, 8'd14, 32'h0, 32'h00008001, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_b13_s", 1'b0, 2'b00, 1'b0, 8'd13, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_b15_u", 1'b0, 2'b00, 1'b1, 8'd15, 32'h0, 32'h00000080, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_w12_u", 1'b0, 2'b10, 1'b1, 8'd12, 32'h0, 32'h8001BEEF, 1'b0, 1'b0, 32'h0, 1'b0);

        // error cases leave memory untouched
        send("st_w4", 1'b1, 2'b10, 1'b0, 8'd4, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("e_st_h5", 1'b1, 2'b01, 1'b0, 8'd5, 32'h0000FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        send("e_ld_w6", 1'b0, 2'b10, 1'b0, 8'd6, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        send("e_ld_sz3", 1'b0, 2'b11, 1'b0, 8'd4, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        send("e_st_sz3", 1'b1, 2'b11, 1'b0, 8'd4, 32'h12345678, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        send("ld_w4_keep", 1'b0, 2'b10, 1'b0, 8'd4, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);
        send("st_b5", 1'b1, 2'b00, 1'b0, 8'd5, 32'h00000077, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        send("ld_w4_b5", 1'b0, 2'b10, 1'b0, 8'd4, 32'h0, 32'hCAFE770D, 1'b0, 1'b0, 32'h0, 1'b0);

        // last word: valid at DEPTH=64, out of range at DEPTH=63
        send("st_w252", 1'b1, 2'b10, 1'b0, 8'd252, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        send("ld_w252", 1'b0, 2'b10, 1'b0, 8'd252, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h0, 1'b1);
        idle();
        repeat (2) @(negedge clk);

        // reset with a load response in flight: response is dropped
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 8'd8;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset_outputs("rst_inflight");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(EXP_READY);

`ifdef DATA_MEM_LSU_CLEAR_EN
        // reset in the middle of the clear sequence restarts it from word 0
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_midclear");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(64);
        send("ld_w8_clr", 1'b0, 2'b10, 1'b0, 8'd8, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
`else
        send("ld_w8_kept", 1'b0, 2'b10, 1'b0, 8'd8, 32'h0, 32'h11F03344, 1'b0, 1'b0, 32'h0, 1'b0);
`endif
        idle();
        repeat (3) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
